// File: rtl/clk_enable_gen.sv
// Lock-qualified multi-channel clock-enable generator: filters PLL lock, sequences a
// downstream reset and produces fractional-rate ce / ce_half strobes per channel.
module clk_enable_gen #(
    parameter int unsigned                 NUM_CH      = 3,
    parameter int unsigned                 ACC_W       = 24,
    parameter logic [NUM_CH*ACC_W-1:0]     INC         = {NUM_CH{24'h800000}},
    parameter int unsigned                 LOCK_FILTER = 1024,
    parameter int unsigned                 RST_HOLD    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_lock,
    input  logic              resync,
    input  logic [NUM_CH-1:0] run_mask,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] ce_half,
    output logic              ready,
    output logic              rst_out_n,
    output logic [7:0]        lock_lost_cnt
);

    localparam int unsigned CNT_MAX = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned SUM_W   = ACC_W + 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ready_nxt;
    logic [7:0]       lost_nxt;
    logic             run_nxt;
    logic             lock_m, lock_s;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            ready         <= 1'b0;
            rst_out_n     <= 1'b0;
            lock_lost_cnt <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ready         <= ready_nxt;
            rst_out_n     <= ready_nxt;
            lock_lost_cnt <= lost_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) state_nxt = FILTER;
            end
            FILTER: begin
                if (!lock_s)                                  state_nxt = WAIT_LOCK;
                else if (cnt == CNT_W'(LOCK_FILTER - 1))      state_nxt = HOLD;
            end
            HOLD: begin
                if (!lock_s)                                  state_nxt = WAIT_LOCK;
                else if (cnt == CNT_W'(RST_HOLD - 1))         state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // Output / counter logic; the dwell counter restarts on every state change
    always_comb begin
        cnt_nxt   = '0;
        ready_nxt = (state_nxt == RUN);
        lost_nxt  = lock_lost_cnt;
        run_nxt   = (state == RUN) && (state_nxt == RUN);
        if ((state == FILTER || state == HOLD) && (state_nxt == state)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        if (state == RUN && !lock_s && lock_lost_cnt != 8'hFF) begin
            lost_nxt = lock_lost_cnt + 8'd1;
        end
    end

    // Per-channel phase accumulators; clear priority: leaving RUN > resync > run_mask
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [SUM_W-1:0] sum;
        logic             tog;
        logic             ce_r;
        logic             half_r;

        assign sum = {1'b0, acc} + {1'b0, INC[i*ACC_W +: ACC_W]};

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc    <= '0;
                tog    <= 1'b0;
                ce_r   <= 1'b0;
                half_r <= 1'b0;
            end else if (!run_nxt || resync || !run_mask[i]) begin
                acc    <= '0;
                tog    <= 1'b0;
                ce_r   <= 1'b0;
                half_r <= 1'b0;
            end else begin
                acc    <= sum[ACC_W-1:0];
                tog    <= tog ^ sum[ACC_W];
                ce_r   <= sum[ACC_W];
                half_r <= sum[ACC_W] & tog;
            end
        end

        assign ce[i]      = ce_r;
        assign ce_half[i] = half_r;
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: lock filter timing, channel rates, resync,
// run_mask restart, lock-loss counting with saturation, and async reset.
module tb_clk_enable_gen;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned ACC_W  = 24;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pll_lock;
    logic              resync;
    logic [NUM_CH-1:0] run_mask;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] ce_half;
    logic              ready;
    logic              rst_out_n;
    logic [7:0]        lock_lost_cnt;

    int checks = 0;
    int errors = 0;

    clk_enable_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .INC        (72'h000000_400000_800000),
        .LOCK_FILTER(8),
        .RST_HOLD   (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .resync       (resync),
        .run_mask     (run_mask),
        .ce           (ce),
        .ce_half      (ce_half),
        .ready        (ready),
        .rst_out_n    (rst_out_n),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected strobes m cycles after a channel (re)start: ch0 every 2, ch1 every 4, ch2 never
    task automatic chk_pattern(input string tag, input int m);
        logic [2:0] exp_ce, exp_half;
        exp_ce   = {1'b0, (m > 0 && m % 4 == 0), (m > 0 && m % 2 == 0)};
        exp_half = {1'b0, (m > 0 && m % 8 == 0), (m > 0 && m % 4 == 0)};
        chk($sformatf("%s_ce_m%0d", tag, m), 32'(ce), 32'(exp_ce));
        chk($sformatf("%s_half_m%0d", tag, m), 32'(ce_half), 32'(exp_half));
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int exp_lost;

        reset_n  = 1'b0;
        pll_lock = 1'b1;
        resync   = 1'b0;
        run_mask = 3'b111;

        // Reset state
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rst_out_n", 32'(rst_out_n), 32'd0);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_lost", 32'(lock_lost_cnt), 32'd0);
        #10 reset_n = 1'b1;

        // Lock steady high: ready/rst_out_n rise on edge 3+8+4 = 15
        for (int e = 1; e <= 15; e++) begin
            tick();
            chk($sformatf("startup_ready_e%0d", e), 32'(ready), 32'(e == 15));
            chk($sformatf("startup_rstn_e%0d", e), 32'(rst_out_n), 32'(e == 15));
            chk($sformatf("startup_ce_e%0d", e), 32'(ce), 32'd0);
        end

        // Channel rates from cycle 0
        for (int m = 0; m < 10; m++) begin
            chk_pattern("rate", m);
            tick();
        end

        // Resync together with run_mask[0] dropped for one cycle
        resync   = 1'b1;
        run_mask = 3'b110;
        tick();
        resync   = 1'b0;
        run_mask = 3'b111;
        for (int m = 0; m < 8; m++) begin
            chk_pattern("resync", m);
            tick();
        end
        chk_pattern("resync", 8);

        // run_mask[1] dropped alone: ch1 restarts from phase 0, ch0 undisturbed
        run_mask = 3'b101;
        tick();
        run_mask = 3'b111;
        chk("mask_ce_m9", 32'(ce), 32'h0);
        tick();
        chk("mask_ce_m10", 32'(ce), 32'h1);
        tick();
        chk("mask_ce_m11", 32'(ce), 32'h0);
        tick();
        chk("mask_ce_m12", 32'(ce), 32'h1);
        chk("mask_half_m12", 32'(ce_half), 32'h1);
        tick();
        chk("mask_ce_m13", 32'(ce), 32'h2);
        chk("mask_half_m13", 32'(ce_half), 32'h0);

        // Lock loss in RUN: seen after 3 edges
        pll_lock = 1'b0;
        tick();
        tick();
        chk("loss_ready_e2", 32'(ready), 32'd1);
        tick();
        chk("loss_ready_e3", 32'(ready), 32'd0);
        chk("loss_rstn_e3", 32'(rst_out_n), 32'd0);
        chk("loss_ce_e3", 32'(ce), 32'd0);
        chk("loss_half_e3", 32'(ce_half), 32'd0);
        chk("loss_cnt_e3", 32'(lock_lost_cnt), 32'd1);

        // One-cycle lock glitch in FILTER: RUN delayed from edge 15 to edge 21
        pll_lock = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int e = 7; e <= 21; e++) begin
            tick();
            chk($sformatf("glitch_ready_e%0d", e), 32'(ready), 32'(e == 21));
        end
        chk("glitch_lost", 32'(lock_lost_cnt), 32'd1);

        // 299 further losses: counter saturates at 255
        for (int i = 0; i < 299; i++) begin
            pll_lock = 1'b0;
            tick();
            tick();
            tick();
            exp_lost = (2 + i > 255) ? 255 : 2 + i;
            chk($sformatf("sat_lost_%0d", i), 32'(lock_lost_cnt), 32'(exp_lost));
            pll_lock = 1'b1;
            wait_ready(ok);
            chk($sformatf("sat_relock_%0d", i), 32'(ok), 32'd1);
            if (!ok) break;
        end

        // Async reset in RUN with ce active
        tick();
        tick();
        chk("pre_rst_ce", 32'(ce), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_ce", 32'(ce), 32'd0);
        chk("async_half", 32'(ce_half), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_rstn", 32'(rst_out_n), 32'd0);
        chk("async_lost", 32'(lock_lost_cnt), 32'd0);

        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
